// File: rtl/vram_write_port.sv
// CPU-side VRAM port: buffers CPU writes in a small FIFO and drains them into the shared SRAM
// whenever the display does not own the port. Reads are ordered behind all earlier writes.
module vram_write_port #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        cpu_wr_req,
  input  logic        cpu_rd_req,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        mode_wr,
  input  logic [7:0]  mode_data,
  input  logic        frame_start,
  output logic        ag,
  output logic [2:0]  gm,
  output logic        css,
  input  logic        vid_slot,
  output logic        sram_en,
  output logic        sram_we,
  output logic [12:0] sram_addr,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_rdata,
  output logic        drop_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrDrain,
    StRdWaitq,
    StRdIssue,
    StRdCapture
  } state_e;

  state_e          state_q;
  logic [20:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            rd_pending_q;
  logic [12:0]     rd_addr_q;
  logic [7:0]      rdata_q;
  logic            rvalid_q, drop_err_q;
  logic            ag_q, css_q;
  logic [2:0]      gm_q;
  // Only the mode bits that reach ag/css/gm are kept.
  logic [4:0]      shadow_q;
  logic [4:0]      mode_src;
  logic            unused_mode_bits;

  logic fifo_full, fifo_empty, push, pop, rd_accept, draining;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cpu_ready  = ~fifo_full & ~rd_pending_q;
  assign push       = cpu_wr_req & cpu_ready;
  assign rd_accept  = cpu_rd_req & ~cpu_wr_req & cpu_ready;
  assign draining   = (state_q == StWrDrain) || (state_q == StRdWaitq);
  assign pop        = draining & ~vid_slot & ~fifo_empty;
  assign count_d    = count_q + CntW'(push) - CntW'(pop);

  assign mode_src         = mode_wr ? mode_data[7:3] : shadow_q;
  assign unused_mode_bits = ^mode_data[2:0];

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign drop_err   = drop_err_q;
  assign ag         = ag_q;
  assign gm         = gm_q;
  assign css        = css_q;

  // SRAM drive is combinational so a display-owned slot blocks the access in the same cycle.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (pop) begin
      sram_en                 = 1'b1;
      sram_we                 = 1'b1;
      {sram_addr, sram_wdata} = fifo_q[rd_ptr_q];
    end else if ((state_q == StRdIssue) && !vid_slot) begin
      sram_en   = 1'b1;
      sram_addr = rd_addr_q;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cpu_addr, cpu_wdata};
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      rdata_q      <= 8'h00;
      rvalid_q     <= 1'b0;
      drop_err_q   <= 1'b0;
      ag_q         <= 1'b0;
      gm_q         <= 3'b000;
      css_q        <= 1'b0;
      shadow_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      // A read colliding with a write is dropped just like a request made while not ready.
      if (((cpu_wr_req | cpu_rd_req) & ~cpu_ready) | (cpu_wr_req & cpu_rd_req)) begin
        drop_err_q <= 1'b1;
      end
      if (rd_accept) begin
        rd_pending_q <= 1'b1;
        rd_addr_q    <= cpu_addr;
      end

      unique case (state_q)
        StIdle: begin
          if (rd_accept || rd_pending_q) begin
            state_q <= StRdWaitq;
          end else if (!fifo_empty) begin
            state_q <= StWrDrain;
          end
        end
        StWrDrain: begin
          if (rd_accept || rd_pending_q) begin
            state_q <= StRdWaitq;
          end else if (count_d == '0) begin
            state_q <= StIdle;
          end
        end
        StRdWaitq: begin
          if (count_d == '0) begin
            state_q <= StRdIssue;
          end
        end
        StRdIssue: begin
          if (!vid_slot) begin
            state_q <= StRdCapture;
          end
        end
        StRdCapture: begin
          rdata_q      <= sram_rdata;
          rvalid_q     <= 1'b1;
          rd_pending_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (mode_wr) begin
        shadow_q <= mode_data[7:3];
      end
      if (frame_start) begin
        ag_q  <= mode_src[0];
        css_q <= mode_src[1];
        gm_q  <= mode_src[4:2];
      end
    end
  end

endmodule

// File: tb/tb_vram_write_port.sv
// Scoreboard bench for vram_write_port: stimulus pushes expected SRAM accesses and read data,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_vram_write_port;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_wr_req = 1'b0, cpu_rd_req = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        mode_wr = 1'b0;
  logic [7:0]  mode_data = '0;
  logic        frame_start = 1'b0;
  logic        ag, css;
  logic [2:0]  gm;
  logic        vid_slot = 1'b0;
  logic        sram_en, sram_we;
  logic [12:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = '0;
  logic        drop_err;

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  data;
  } sram_t;

  sram_t      exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] mem [8192];
  int         n_tests = 0;
  int         n_fail = 0;
  int         sram_wr_cnt = 0;
  int         base;

  always #5 pixel_clock = ~pixel_clock;

  vram_write_port #(.FIFO_DEPTH(4)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .cpu_wr_req  (cpu_wr_req),
    .cpu_rd_req  (cpu_rd_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .mode_wr     (mode_wr),
    .mode_data   (mode_data),
    .frame_start (frame_start),
    .ag          (ag),
    .gm          (gm),
    .css         (css),
    .vid_slot    (vid_slot),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .drop_err    (drop_err)
  );

  // Synchronous SRAM with one-cycle read latency.
  always @(posedge pixel_clock) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge pixel_clock) begin
    sram_t e;
    if (sram_en) begin
      check("sram_en_in_vid_slot", {31'b0, vid_slot}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sram: we=%0b addr=0x%0h data=0x%0h, expected no access",
                 sram_we, sram_addr, sram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("sram_we", {31'b0, sram_we}, {31'b0, e.we});
        check("sram_addr", {19'b0, sram_addr}, {19'b0, e.addr});
        if (e.we) check("sram_wdata", {24'b0, sram_wdata}, {24'b0, e.data});
      end
      if (sram_we) sram_wr_cnt++;
    end else if (sram_we) begin
      check("sram_we_without_en", {31'b0, sram_we}, 32'd0);
    end
    if (cpu_rvalid) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: rdata=0x%0h, expected no read", cpu_rdata);
      end else begin
        check("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, rd_q.pop_front()});
      end
    end
  end

  // All stimulus changes happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic do_wr(input logic [12:0] a, input logic [7:0] d);
    cpu_wr_req = 1'b1;
    cpu_addr   = a;
    cpu_wdata  = d;
    step();
    cpu_wr_req = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && k < budget) begin
      @(negedge pixel_clock);
      k++;
    end
    step();
    check("scoreboard_drained", exp_q.size() + rd_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge pixel_clock);
    check({tag, "_sram_en"}, {31'b0, sram_en}, 32'd0);
    check({tag, "_sram_we"}, {31'b0, sram_we}, 32'd0);
    check({tag, "_cpu_rdata"}, {24'b0, cpu_rdata}, 32'h00);
    check({tag, "_cpu_rvalid"}, {31'b0, cpu_rvalid}, 32'd0);
    check({tag, "_drop_err"}, {31'b0, drop_err}, 32'd0);
    check({tag, "_mode"}, {27'b0, ag, gm, css}, 32'd0);
    check({tag, "_cpu_ready"}, {31'b0, cpu_ready}, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    // Two writes drain in order on the following cycles.
    vid_slot = 1'b0;
    exp_q.push_back('{1'b1, 13'h0010, 8'h1A});
    exp_q.push_back('{1'b1, 13'h0011, 8'h2B});
    do_wr(13'h0010, 8'h1A);
    do_wr(13'h0011, 8'h2B);
    wait_empty(10);

    // FIFO overflow with the display holding the port.
    base = sram_wr_cnt;
    vid_slot = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back('{1'b1, 13'h0100 + 13'(i), 8'hA0 + 8'(i)});
      do_wr(13'h0100 + 13'(i), 8'hA0 + 8'(i));
    end
    @(negedge pixel_clock);
    check("full_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("overflow_drop_err", {31'b0, drop_err}, 32'd1);
    check("held_no_writes", sram_wr_cnt - base, 32'd0);
    step();
    vid_slot = 1'b0;
    wait_empty(20);
    check("overflow_write_count", sram_wr_cnt - base, 32'd4);

    // Read after write at the top address sees the written byte.
    exp_q.push_back('{1'b1, 13'h1FFF, 8'h55});
    exp_q.push_back('{1'b0, 13'h1FFF, 8'h00});
    rd_q.push_back(8'h55);
    do_wr(13'h1FFF, 8'h55);
    cpu_rd_req = 1'b1;
    cpu_addr   = 13'h1FFF;
    step();
    cpu_rd_req = 1'b0;
    @(negedge pixel_clock);
    check("rd_pending_blocks_ready", {31'b0, cpu_ready}, 32'd0);
    step();
    wait_empty(20);
    @(negedge pixel_clock);
    check("rdata_held", {24'b0, cpu_rdata}, 32'h55);
    check("ready_after_read", {31'b0, cpu_ready}, 32'd1);
    step();

    // Display slot toggling during a two-entry drain.
    base = sram_wr_cnt;
    vid_slot = 1'b1;
    exp_q.push_back('{1'b1, 13'h0200, 8'h11});
    exp_q.push_back('{1'b1, 13'h0201, 8'h22});
    do_wr(13'h0200, 8'h11);
    do_wr(13'h0201, 8'h22);
    vid_slot = 1'b1; step();
    vid_slot = 1'b0; step();
    check("toggle_after_first_slot", sram_wr_cnt - base, 32'd1);
    vid_slot = 1'b1; step();
    vid_slot = 1'b0; step();
    check("toggle_write_count", sram_wr_cnt - base, 32'd2);
    wait_empty(10);

    // Mode latch: shadowed until frame_start.
    mode_wr = 1'b1;
    mode_data = 8'h18;
    step();
    mode_wr = 1'b0;
    mode_data = 8'h00;
    step();
    @(negedge pixel_clock);
    check("mode_before_frame", {27'b0, ag, gm, css}, 32'd0);
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    @(negedge pixel_clock);
    check("mode_after_frame_ag", {31'b0, ag}, 32'd1);
    check("mode_after_frame_css", {31'b0, css}, 32'd1);
    check("mode_after_frame_gm", {29'b0, gm}, 32'd0);
    step();
    mode_wr = 1'b1;
    mode_data = 8'hE0;
    frame_start = 1'b1;
    step();
    mode_wr = 1'b0;
    frame_start = 1'b0;
    @(negedge pixel_clock);
    check("mode_same_cycle", {27'b0, ag, gm, css}, {27'b0, 1'b0, 3'b111, 1'b0});
    step();

    // Reset with queued writes discards them.
    base = sram_wr_cnt;
    vid_slot = 1'b1;
    do_wr(13'h0300, 8'h01);
    do_wr(13'h0301, 8'h02);
    do_wr(13'h0302, 8'h03);
    reset = 1'b0;
    vid_slot = 1'b0;
    check_reset_outputs("midreset");
    step();
    reset = 1'b1;
    repeat (6) step();
    check("no_writes_after_reset", sram_wr_cnt - base, 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    @(negedge pixel_clock);
    check("shadow_cleared", {27'b0, ag, gm, css}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_write_port.md
VRAM_WRITE_PORT -- requirements
Module: vram_write_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the write FIFO entries (power of two, 2..16).
REQ-002 SHALL have port pixel_clock, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cpu_wr_req, input, 1, CPU VRAM write request, one cycle per request.
REQ-005 SHALL have port cpu_rd_req, input, 1, CPU VRAM read request, one cycle per request.
REQ-006 SHALL have port cpu_addr, input, 13, VRAM byte address for the request.
REQ-007 SHALL have port cpu_wdata, input, 8, write data.
REQ-008 SHALL have port cpu_ready, output, 1, high when a request is accepted this cycle.
REQ-009 SHALL have port cpu_rdata, output, 8, read data, held until the next read completes.
REQ-010 SHALL have port cpu_rvalid, output, 1, one-cycle pulse marking cpu_rdata valid.
REQ-011 SHALL have port mode_wr, input, 1, write strobe for the video mode latch.
REQ-012 SHALL have port mode_data, input, 8, mode latch data: bit3=ag, bit4=css, bits7:5=gm.
REQ-013 SHALL have port frame_start, input, 1, one-cycle pulse at the first border line of each frame.
REQ-014 SHALL have ports ag (output, 1), gm (output, 3) and css (output, 1), the active video mode.
REQ-015 SHALL have port vid_slot, input, 1, high when the display owns the VRAM port this cycle.
REQ-016 SHALL have ports sram_en (output, 1), sram_we (output, 1), sram_addr (output, 13), sram_wdata (output, 8) and sram_rdata (input, 8), the synchronous SRAM port with 1-cycle read latency.
REQ-017 SHALL have port drop_err, output, 1, sticky flag for a request made while cpu_ready was low.

Function
REQ-018 SHALL drive cpu_ready = ~fifo_full & ~rd_pending, combinationally.
REQ-019 SHALL push {cpu_addr, cpu_wdata} into the FIFO at the clock edge where cpu_wr_req & cpu_ready.
REQ-020 SHALL give cpu_wr_req precedence over a simultaneous cpu_rd_req; the read is ignored and drop_err is set.
REQ-021 SHALL set drop_err on any cpu_wr_req or cpu_rd_req sampled while cpu_ready is low, and SHALL leave all state otherwise unchanged.
REQ-022 SHALL implement the states IDLE, WR_DRAIN, RD_WAITQ, RD_ISSUE and RD_CAPTURE.
REQ-023 IDLE -> WR_DRAIN SHALL occur when the FIFO is non-empty; IDLE -> RD_WAITQ SHALL occur on an accepted read.
REQ-024 In WR_DRAIN, each cycle with vid_slot=0 SHALL drive sram_en=1, sram_we=1 and the FIFO head on addr/wdata, and pop at that edge.
REQ-025 In WR_DRAIN, a cycle with vid_slot=1 SHALL drive sram_en=0 and SHALL not pop.
REQ-026 WR_DRAIN SHALL return to IDLE when the FIFO becomes empty; pushes during WR_DRAIN are allowed.
REQ-027 An accepted read SHALL latch cpu_addr and set rd_pending; RD_WAITQ SHALL drain the FIFO fully first, as in WR_DRAIN, so that the read sees all earlier writes.
REQ-028 RD_WAITQ -> RD_ISSUE SHALL occur when the FIFO is empty.
REQ-029 In RD_ISSUE, the first cycle with vid_slot=0 SHALL drive sram_en=1, sram_we=0 and the latched address, then go to RD_CAPTURE.
REQ-030 RD_CAPTURE SHALL register sram_rdata into cpu_rdata at its ending edge, pulse cpu_rvalid in the next cycle, clear rd_pending and return to IDLE.
REQ-031 SHALL drive sram_en=0 whenever vid_slot=1; sram_we SHALL never be high while sram_en is low.
REQ-032 SHALL store mode_data in a shadow register on mode_wr; ag/gm/css SHALL update from the shadow only at the edge where frame_start=1.
REQ-033 When mode_wr and frame_start occur in the same cycle, SHALL apply the new mode_data directly at that edge.
REQ-034 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with a count register of width log2(FIFO_DEPTH)+1.

Reset
REQ-035 While reset=0, SHALL clear the FIFO, set state to IDLE, clear rd_pending, and drive cpu_rdata=0x00, cpu_rvalid=0, drop_err=0, ag=0, gm=000, css=0, shadow=0x00 and sram_en=sram_we=0.
REQ-036 A reset asserted mid-drain or mid-read SHALL discard pending writes and the read with no SRAM access, and SHALL apply immediately.

Verification
REQ-037 SHALL verify: writes 0x1A->0x0010 and 0x2B->0x0011 with vid_slot=0 -> SRAM writes on the 2 following cycles, in order.
REQ-038 SHALL verify: 5 back-to-back writes with vid_slot=1 held (DEPTH 4) -> cpu_ready low after 4, the 5th sets drop_err, and after vid_slot drops exactly 4 SRAM writes occur.
REQ-039 SHALL verify: write 0x55->0x1FFF then read 0x1FFF -> read issued after the write, cpu_rvalid with cpu_rdata=0x55.
REQ-040 SHALL verify: vid_slot toggling 1,0,1,0 during a 2-entry drain -> sram_en only in vid_slot=0 cycles.
REQ-041 SHALL verify: mode_wr 0x18 mid-frame -> ag/css unchanged until frame_start, then ag=1 and css=1.
REQ-042 SHALL verify: reset asserted with 3 queued writes -> no further SRAM writes, all outputs at reset values.
